addr_bus_sequencer: RTL and testbench
=====================================

Name: addr_bus_sequencer

Overview:
Parametrised successor to the combinational address-bus mux. Selects one of NSRC address sources, registers it onto the memory address bus and runs single or burst accesses with auto-increment and a MEM_READY wait-state handshake. Sits between the CPU datapath (PC, ALU result, ALU A input, future sources) and the memory/IO bus interface.

Parameters:
ADDR_W, 16, address width in bits
NSRC, 3, number of address sources (0=PC_A, 1=ALU_R, 2=ALUA_DIN by convention)
SEL_W, 2, width of ADDR_BUSX select
DEFAULT_SEL, 2, source used when ADDR_BUSX >= NSRC
LEN_W, 4, burst length field width

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  synchronous, active-high reset
SRC_DIN  input  NSRC*ADDR_W  packed sources; source k at bits [k*ADDR_W +: ADDR_W]
ADDR_BUSX  input  SEL_W  source select, sampled on START
START  input  1  begin access; honoured only in IDLE
BURST_LEN  input  LEN_W  beats in access; 0 treated as 1; sampled on START
STEP  input  ADDR_W  per-beat address increment, sampled on START
MEM_READY  input  1  memory accepts current beat this cycle
ADDR  output  ADDR_W  registered address bus
ADDR_VALID  output  1  ADDR holds a beat awaiting MEM_READY
BUSY  output  1  high in any state other than IDLE
DONE  output  1  one-cycle pulse on final beat acceptance
WRAP  output  1  sticky: an increment overflowed ADDR_W within current access

Behaviour:
- Reset: state=IDLE; ADDR=0, ADDR_VALID=0, BUSY=0, DONE=0, WRAP=0; beat counter=0. RESET overrides all inputs on the same edge, including mid-burst; no DONE is generated for an aborted access.
- States: IDLE, ISSUE.
- IDLE: ADDR holds its last value. On START: ADDR <= SRC_DIN[sel]; sel = ADDR_BUSX if ADDR_BUSX < NSRC, else DEFAULT_SEL. Latch remaining = (BURST_LEN==0 ? 1 : BURST_LEN) and STEP; WRAP <= 0; go to ISSUE. ADDR_VALID and BUSY rise the cycle after START (1-cycle latency).
- ISSUE: ADDR_VALID=1, ADDR stable until acceptance. Beat accepted when ADDR_VALID && MEM_READY on a rising edge.
  - remaining==1: DONE=1 next cycle; go IDLE; ADDR_VALID=0; ADDR keeps final beat address.
  - else: ADDR <= (ADDR + STEP) mod 2^ADDR_W; remaining -= 1; WRAP <= 1 if the sum carried out of ADDR_W; stay in ISSUE.
  - MEM_READY low: hold everything; waits are unbounded.
- START while BUSY is ignored; SRC_DIN/ADDR_BUSX/BURST_LEN/STEP changes after START have no effect on the running access.
- DONE is exactly one cycle wide. START in the DONE-pulse cycle (state IDLE) is accepted, so back-to-back accesses have one idle cycle between last acceptance and next ADDR_VALID.
- Zero STEP is legal: the same address is repeated for every beat.
- Maximum burst is 2^LEN_W - 1 beats.

Test Plan:
- Reset mid-burst: START with BURST_LEN=4, MEM_READY=1, assert RESET after 2 beats -> next cycle ADDR=0, ADDR_VALID=0, BUSY=0, no DONE pulse.
- Single access: SRC_DIN={ALUA_DIN=16'h3000, ALU_R=16'h2000, PC_A=16'h1000}, ADDR_BUSX=1, BURST_LEN=0, MEM_READY=1 -> one cycle later ADDR=16'h2000, ADDR_VALID=1; the following cycle DONE=1, BUSY=0.
- Select fallback: ADDR_BUSX=3 with NSRC=3 -> ADDR=16'h3000.
- Wait states and burst: PC_A=16'h0100, BURST_LEN=3, STEP=2, MEM_READY low for 2 cycles per beat -> ADDR sequence 0100, 0102, 0104, each held through its waits; a single DONE after the third acceptance.
- Wrap: ALU_R=16'hFFFE, STEP=2, BURST_LEN=2 -> ADDR FFFE then 0000, WRAP=1 and held until the next START.
- Ignored START: assert START with a different source during a burst -> ADDR sequence unchanged; back-to-back START in the DONE cycle is accepted.

Source files
------------

// File: rtl/addr_bus_sequencer.sv
// Selects one of NSRC address sources and runs single/burst accesses onto a registered address bus.
// Latency: ADDR_VALID one cycle after START; each beat holds until MEM_READY, waits are unbounded.
module addr_bus_sequencer #(
   parameter int ADDR_W      = 16,
   parameter int NSRC        = 3,
   parameter int SEL_W       = 2,
   parameter int DEFAULT_SEL = 2,
   parameter int LEN_W       = 4
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [NSRC*ADDR_W-1:0] SRC_DIN,
   input  logic [SEL_W-1:0]       ADDR_BUSX,
   input  logic                   START,
   input  logic [LEN_W-1:0]       BURST_LEN,
   input  logic [ADDR_W-1:0]      STEP,
   input  logic                   MEM_READY,
   output logic [ADDR_W-1:0]      ADDR,
   output logic                   ADDR_VALID,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   WRAP
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] step_q, step_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              done_q, done_d;
   logic              wrap_q, wrap_d;

   int                sel_idx;
   logic [ADDR_W-1:0] src_sel;
   logic [ADDR_W:0]   sum_w;

   // Out-of-range selects fall back to DEFAULT_SEL rather than reading past the packed bus.
   always_comb begin
      sel_idx = (int'(ADDR_BUSX) < NSRC) ? int'(ADDR_BUSX) : DEFAULT_SEL;
      src_sel = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (sel_idx == k) begin
            src_sel = SRC_DIN[k*ADDR_W +: ADDR_W];
         end
      end
   end

   assign sum_w = {1'b0, addr_q} + {1'b0, step_q};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      step_d  = step_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      wrap_d  = wrap_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               addr_d  = src_sel;
               step_d  = STEP;
               rem_d   = (BURST_LEN == '0) ? LEN_W'(1) : BURST_LEN;
               wrap_d  = 1'b0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (MEM_READY) begin
               if (rem_q == LEN_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  addr_d = sum_w[ADDR_W-1:0];
                  rem_d  = rem_q - LEN_W'(1);
                  if (sum_w[ADDR_W]) begin
                     wrap_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         addr_q  <= '0;
         step_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         step_q  <= step_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   assign ADDR       = addr_q;
   assign ADDR_VALID = (state_q == ISSUE);
   assign BUSY       = (state_q == ISSUE);
   assign DONE       = done_q;
   assign WRAP       = wrap_q;

endmodule

// File: tb/tb_addr_bus_sequencer.sv
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_addr_bus_sequencer;

   localparam int ADDR_W = 16;
   localparam int NSRC   = 3;
   localparam int SEL_W  = 2;
   localparam int LEN_W  = 4;

   logic                   CLK = 1'b0;
   logic                   RESET;
   logic [NSRC*ADDR_W-1:0] SRC_DIN;
   logic [SEL_W-1:0]       ADDR_BUSX;
   logic                   START;
   logic [LEN_W-1:0]       BURST_LEN;
   logic [ADDR_W-1:0]      STEP;
   logic                   MEM_READY;
   logic [ADDR_W-1:0]      ADDR;
   logic                   ADDR_VALID;
   logic                   BUSY;
   logic                   DONE;
   logic                   WRAP;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_n = 0;

   // Reference model: an access is base + i*step for beat i; wrap once the unbounded sum reaches 2^16.
   bit  m_busy = 0;
   bit  m_done = 0;
   bit  m_wrap = 0;
   int  m_addr = 0;
   int  a_base, a_step, a_len, a_beat;

   always #5 CLK = ~CLK;

   addr_bus_sequencer #(
      .ADDR_W(ADDR_W), .NSRC(NSRC), .SEL_W(SEL_W), .DEFAULT_SEL(2), .LEN_W(LEN_W)
   ) dut (
      .CLK(CLK), .RESET(RESET), .SRC_DIN(SRC_DIN), .ADDR_BUSX(ADDR_BUSX),
      .START(START), .BURST_LEN(BURST_LEN), .STEP(STEP), .MEM_READY(MEM_READY),
      .ADDR(ADDR), .ADDR_VALID(ADDR_VALID), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc_n, obs, exp);
      end
   endtask

   task automatic model_edge();
      int sel;
      int cur;
      if (RESET) begin
         m_busy = 0; m_done = 0; m_wrap = 0; m_addr = 0;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (START) begin
               sel    = (int'(ADDR_BUSX) < NSRC) ? int'(ADDR_BUSX) : 2;
               a_base = int'(SRC_DIN[sel*ADDR_W +: ADDR_W]);
               a_len  = (BURST_LEN == 0) ? 1 : int'(BURST_LEN);
               a_step = int'(STEP);
               a_beat = 0;
               m_busy = 1;
               m_addr = a_base;
               m_wrap = 0;
            end
         end else if (MEM_READY) begin
            if (a_beat == a_len - 1) begin
               m_busy = 0;
               m_done = 1;
            end else begin
               a_beat++;
               cur    = a_base + a_beat * a_step;
               m_addr = cur % 65536;
               m_wrap = (cur >= 65536);
            end
         end
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge CLK);
      #1;
      cyc_n++;
      chk("addr",  32'(ADDR),       32'(m_addr));
      chk("valid", 32'(ADDR_VALID), 32'(m_busy));
      chk("busy",  32'(BUSY),       32'(m_busy));
      chk("done",  32'(DONE),       32'(m_done));
      chk("wrap",  32'(WRAP),       32'(m_wrap));
   endtask

   initial begin
      RESET = 1; SRC_DIN = '0; ADDR_BUSX = '0; START = 0;
      BURST_LEN = '0; STEP = '0; MEM_READY = 0;
      cyc(); cyc();
      chk("rst_addr", 32'(ADDR), 32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
      RESET = 0;
      cyc();

      // Single access from ALU_R
      SRC_DIN = {16'h3000, 16'h2000, 16'h1000};
      ADDR_BUSX = 2'd1; BURST_LEN = 4'd0; MEM_READY = 1; START = 1;
      cyc(); START = 0;
      chk("single_addr", 32'(ADDR), 32'h2000);
      chk("single_valid", 32'(ADDR_VALID), 32'h1);
      cyc();
      chk("single_done", 32'(DONE), 32'h1);
      chk("single_busy", 32'(BUSY), 32'h0);

      // Out-of-range select falls back to ALUA_DIN
      ADDR_BUSX = 2'd3; START = 1;
      cyc(); START = 0;
      chk("fallback_addr", 32'(ADDR), 32'h3000);
      cyc();

      // Reset two beats into a 4-beat burst
      ADDR_BUSX = 2'd0; BURST_LEN = 4'd4; STEP = 16'd1; START = 1;
      cyc(); START = 0;
      cyc(); cyc();
      RESET = 1;
      cyc(); RESET = 0;
      chk("abort_addr", 32'(ADDR), 32'h0);
      chk("abort_valid", 32'(ADDR_VALID), 32'h0);
      chk("abort_busy", 32'(BUSY), 32'h0);
      chk("abort_done", 32'(DONE), 32'h0);
      cyc();
      chk("abort_nodone", 32'(DONE), 32'h0);

      // Burst with two wait states per beat
      SRC_DIN = {16'h3000, 16'h2000, 16'h0100};
      ADDR_BUSX = 2'd0; BURST_LEN = 4'd3; STEP = 16'd2; MEM_READY = 0; START = 1;
      cyc(); START = 0;
      for (int b = 0; b < 3; b++) begin
         chk("burst_addr", 32'(ADDR), 32'h0100 + 32'(2 * b));
         cyc();
         chk("burst_wait1", 32'(ADDR), 32'h0100 + 32'(2 * b));
         cyc();
         chk("burst_wait2", 32'(ADDR), 32'h0100 + 32'(2 * b));
         MEM_READY = 1;
         cyc();
         MEM_READY = 0;
         chk("burst_done", 32'(DONE), (b == 2) ? 32'h1 : 32'h0);
      end
      cyc();

      // Address wrap
      SRC_DIN = {16'h3000, 16'hFFFE, 16'h0100};
      ADDR_BUSX = 2'd1; BURST_LEN = 4'd2; STEP = 16'd2; MEM_READY = 1; START = 1;
      cyc(); START = 0;
      chk("wrap_a0", 32'(ADDR), 32'hFFFE);
      chk("wrap_w0", 32'(WRAP), 32'h0);
      cyc();
      chk("wrap_a1", 32'(ADDR), 32'h0000);
      chk("wrap_w1", 32'(WRAP), 32'h1);
      cyc();
      chk("wrap_done", 32'(DONE), 32'h1);
      MEM_READY = 0;
      cyc();
      chk("wrap_held", 32'(WRAP), 32'h1);

      // START during a burst is ignored; START in the DONE cycle is accepted
      SRC_DIN = {16'h3000, 16'h2000, 16'h0200};
      ADDR_BUSX = 2'd0; BURST_LEN = 4'd3; STEP = 16'd1; MEM_READY = 1; START = 1;
      cyc();
      chk("ign_a0", 32'(ADDR), 32'h0200);
      chk("ign_wrapclr", 32'(WRAP), 32'h0);
      SRC_DIN = {16'h4444, 16'h5555, 16'h6666};
      ADDR_BUSX = 2'd2;
      cyc();
      chk("ign_a1", 32'(ADDR), 32'h0201);
      cyc();
      chk("ign_a2", 32'(ADDR), 32'h0202);
      cyc();
      chk("b2b_done", 32'(DONE), 32'h1);
      chk("b2b_idle", 32'(BUSY), 32'h0);
      cyc(); START = 0;
      chk("b2b_busy", 32'(BUSY), 32'h1);
      chk("b2b_addr", 32'(ADDR), 32'h4444);
      for (int i = 0; i < 16; i++) cyc();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         RESET     = ($urandom_range(0, 199) == 0);
         START     = ($urandom_range(0, 9) < 3);
         MEM_READY = ($urandom_range(0, 9) < 6);
         ADDR_BUSX = SEL_W'($urandom_range(0, 3));
         BURST_LEN = LEN_W'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0:       STEP = '0;
            1:       STEP = 16'hFFFF - 16'($urandom_range(0, 15));
            default: STEP = 16'($urandom);
         endcase
         for (int k = 0; k < NSRC; k++) begin
            SRC_DIN[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 1) == 0)
               ? 16'hFFFF - 16'($urandom_range(0, 63)) : 16'($urandom);
         end
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
